// File: rtl/sistema_btn_pio.sv
// -----------------------------------------------------------------------------
// sistema_btn_pio
//
// Push-button parallel input port with an Avalon-MM slave interface.
// Each external pin is synchronized (2 flops), debounced by a per-bit counter,
// and edge-detected on the debounced ("stable") value.  Detected edges latch
// into edgecapture, which can be masked onto a level interrupt.
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous, active-high
//   address     word address: 0 data, 1 reserved, 2 irqmask, 3 edgecapture
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (low WIDTH bits used)
//   readdata    combinational read data, zero when not selected
//   in_port     asynchronous button pins
//   irq         OR of (edgecapture & irqmask)
//
// Bus handshake: the slave is always ready.  A write is accepted on every
// rising clk edge where chipselect=1 and write_n=0; a read needs no strobe,
// readdata follows address combinationally while chipselect=1.
// -----------------------------------------------------------------------------
module sistema_btn_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1      // 0 rising, 1 falling, 2 any
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Smallest width that can hold DEBOUNCE_CYCLES-1.
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [CW-1:0]    cnt [WIDTH];

    logic [WIDTH-1:0] accept;      // bit's new level is accepted this edge
    logic [WIDTH-1:0] edge_hit;    // accepted change with the chosen polarity
    logic [WIDTH-1:0] clear_bits;  // write-1-clear mask for edgecapture
    logic             wr_en;

    // Only the low WIDTH bits of writedata carry meaning.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect & ~write_n;

    // A bit is accepted when it still differs and has already differed for
    // DEBOUNCE_CYCLES-1 earlier edges, i.e. this is the DEBOUNCE_CYCLES-th.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    // A falling edge is an accepted bit whose current stable value is 1.
    always_comb begin
        edge_hit = '0;
        case (EDGE_TYPE)
            0:       edge_hit = accept & ~stable;
            1:       edge_hit = accept & stable;
            default: edge_hit = accept;
        endcase
    end

    assign clear_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Synchronizer and stable value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
        end else begin
            sync1  <= in_port;
            sync2  <= sync1;
            stable <= stable ^ accept;
        end
    end

    // Debounce counters: count consecutive mismatches, clear on match or
    // on acceptance, so the counter never exceeds CNT_MAX.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i] || cnt[i] == CNT_MAX) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Interrupt mask and edge capture.  A new edge overrides a simultaneous
    // write-1-clear so that an event is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecapture <= (edgecapture & ~clear_bits) | edge_hit;
        end
    end

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                2'd0:    readdata[WIDTH-1:0] = stable;
                2'd2:    readdata[WIDTH-1:0] = irqmask;
                2'd3:    readdata[WIDTH-1:0] = edgecapture;
                default: readdata = '0;
            endcase
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_sistema_btn_pio.sv
module tb_sistema_btn_pio;

    localparam int W = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [W-1:0] in_port = '0;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    sistema_btn_pio #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .EDGE_TYPE(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Pins reach the debouncer two edges late; a pin level is accepted once
    // it has differed from the stable value for D consecutive edges.
    logic [W-1:0] m_st = '0;
    logic [W-1:0] m_mask = '0;
    logic [W-1:0] m_cap = '0;
    int           m_run [W];
    logic [W-1:0] m_pipe [$];

    task automatic model_update();
        logic [W-1:0] s;
        logic [W-1:0] hit;
        logic [W-1:0] clr;
        if (reset) begin
            m_st = '0;
            m_mask = '0;
            m_cap = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            m_pipe.delete();
            m_pipe.push_back('0);
            m_pipe.push_back('0);
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(in_port);
            hit = '0;
            for (int i = 0; i < W; i++) begin
                if (s[i] != m_st[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == D) begin
                        if (m_st[i]) hit[i] = 1'b1;
                        m_st[i] = s[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            clr = '0;
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            if (chipselect && !write_n && address == 2'd3) clr = writedata[W-1:0];
            m_cap = (m_cap & ~clr) | hit;
        end
    endtask

    function automatic logic [31:0] model_rd();
        logic [31:0] r;
        r = '0;
        if (chipselect) begin
            case (address)
                2'd0: r[W-1:0] = m_st;
                2'd2: r[W-1:0] = m_mask;
                2'd3: r[W-1:0] = m_cap;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic rst_i, input logic [W-1:0] in_i,
                        input logic cs_i, input logic wn_i,
                        input logic [1:0] addr_i, input logic [31:0] wd_i);
        @(negedge clk);
        reset      = rst_i;
        in_port    = in_i;
        chipselect = cs_i;
        write_n    = wn_i;
        address    = addr_i;
        writedata  = wd_i;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         rst;
        logic [W-1:0] in;
        logic         cs;
        logic         wn;
        logic [1:0]   addr;
        logic [31:0]  wd;
        logic [31:0]  exp_rd;
        logic         exp_irq;
    } vec_t;

    vec_t vecs [$];

    task automatic add_vec(input logic rst_i, input logic [W-1:0] in_i, input logic cs_i,
                           input logic wn_i, input logic [1:0] addr_i, input logic [31:0] wd_i,
                           input logic [31:0] rd_i, input logic irq_i);
        vec_t v;
        v.rst = rst_i; v.in = in_i; v.cs = cs_i; v.wn = wn_i;
        v.addr = addr_i; v.wd = wd_i; v.exp_rd = rd_i; v.exp_irq = irq_i;
        vecs.push_back(v);
    endtask

    initial begin
        logic [W-1:0] cur_in;
        logic [W-1:0] drv_in;
        logic         rst_r;

        m_pipe.push_back('0);
        m_pipe.push_back('0);
        for (int i = 0; i < W; i++) m_run[i] = 0;

        // Reset, then all-high pins accepted on the 6th edge (no falling edge).
        add_vec(1, 4'hF, 1, 1, 2'd0, 0, 32'h0, 0);
        for (int k = 1; k <= 5; k++) add_vec(0, 4'hF, 1, 1, 2'd0, 0, 32'h0, 0);
        add_vec(0, 4'hF, 1, 1, 2'd0, 0, 32'hF, 0);
        add_vec(0, 4'hF, 1, 1, 2'd3, 0, 32'h0, 0);
        // Bit 0 falls: data and edgecapture update on the 6th edge.
        for (int k = 1; k <= 4; k++) add_vec(0, 4'hE, 1, 1, 2'd0, 0, 32'hF, 0);
        add_vec(0, 4'hE, 1, 1, 2'd3, 0, 32'h0, 0);
        add_vec(0, 4'hE, 1, 1, 2'd3, 0, 32'h1, 0);
        add_vec(0, 4'hE, 1, 1, 2'd0, 0, 32'hE, 0);
        // Unmask -> irq; write-1-clear -> irq drops.
        add_vec(0, 4'hE, 1, 0, 2'd2, 32'h1, 32'h1, 1);
        add_vec(0, 4'hE, 1, 0, 2'd3, 32'h1, 32'h0, 0);
        add_vec(0, 4'hE, 1, 1, 2'd2, 0, 32'h1, 0);
        add_vec(0, 4'hE, 0, 1, 2'd2, 0, 32'h0, 0);
        // Writes to addresses 0 and 1 have no effect.
        add_vec(0, 4'hE, 1, 0, 2'd0, 32'hFFFF_FFFF, 32'hE, 0);
        add_vec(0, 4'hE, 1, 0, 2'd1, 32'hFFFF_FFFF, 32'h0, 0);
        add_vec(0, 4'hE, 1, 1, 2'd0, 0, 32'hE, 0);

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].in, vecs[k].cs, vecs[k].wn, vecs[k].addr, vecs[k].wd);
            check($sformatf("vec%0d_rd", k), readdata, vecs[k].exp_rd);
            check($sformatf("vec%0d_irq", k), {31'b0, irq}, {31'b0, vecs[k].exp_irq});
        end

        // Glitch: bit 1 low for 3 cycles is rejected.
        for (int k = 0; k < 3; k++) step(0, 4'hC, 1, 1, 2'd0, 0);
        for (int k = 0; k < 8; k++) begin
            step(0, 4'hE, 1, 1, 2'd0, 0);
            check("glitch_data", readdata, 32'hE);
        end
        step(0, 4'hE, 1, 1, 2'd3, 0);
        check("glitch_cap", readdata, 32'h0);
        check("glitch_irq", {31'b0, irq}, 32'h0);

        // Set wins over a simultaneous write-1-clear on bit 0.
        for (int k = 0; k < 6; k++) step(0, 4'hF, 1, 1, 2'd0, 0);
        check("rise_data", readdata, 32'hF);
        step(0, 4'hF, 1, 1, 2'd3, 0);
        check("rise_nocap", readdata, 32'h0);
        for (int k = 0; k < 5; k++) step(0, 4'hE, 1, 1, 2'd3, 0);
        check("pre_accept_cap", readdata, 32'h0);
        step(0, 4'hE, 1, 0, 2'd3, 32'h1);
        check("set_wins_cap", readdata, 32'h1);
        check("set_wins_irq", {31'b0, irq}, 32'h1);
        step(0, 4'hE, 1, 0, 2'd3, 32'h1);
        check("clear_cap", readdata, 32'h0);

        // Reset mid-debounce restarts the count.
        step(0, 4'hF, 1, 1, 2'd0, 0);
        step(0, 4'hF, 1, 1, 2'd0, 0);
        step(1, 4'hF, 1, 0, 2'd2, 32'hF);
        check("rst_data", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 4'hF, 1, 1, 2'd0, 0);
            check($sformatf("rst_hold%0d", k), readdata, 32'h0);
        end
        step(0, 4'hF, 1, 1, 2'd0, 0);
        check("rst_accept", readdata, 32'hF);
        step(0, 4'hF, 1, 1, 2'd2, 0);
        check("rst_mask", readdata, 32'h0);

        // Randomized traffic against the model.
        step(1, 4'h0, 0, 1, 2'd0, 0);
        cur_in = '0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) < 2) cur_in = W'($urandom_range(0, 15));
            drv_in = cur_in;
            if ($urandom_range(0, 15) == 0) drv_in = cur_in ^ W'(1 << $urandom_range(0, W - 1));
            rst_r = ($urandom_range(0, 499) == 0);
            step(rst_r, drv_in, ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) != 0),
                 2'($urandom_range(0, 3)), $urandom);
            check("rand_rd", readdata, model_rd());
            check("rand_irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
